// File: rtl/busreq_pkg.sv
// Shared types for the BUSREQ responder: request codes, FSM states, wait-state timeout.
package busreq_pkg;

  typedef enum logic [3:0] {
    REQ_IDLE    = 4'b0000,
    REQ_READ    = 4'b0001,
    REQ_WRITE   = 4'b0010,
    REQ_NEXT_OP = 4'b0011
  } busreq_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_RESPOND,
    S_HOLD
  } state_e;

  localparam int ERR_TIMEOUT = 16;

endpackage

// File: rtl/busreq_responder_queue.sv
// Circular operand FIFO; push is ignored when full, pop is ignored when empty.
// Head data is visible combinationally on pop_dat_o.
module operand_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/busreq_responder.sv
// BUSREQ responder: 16-entry register file plus operand queue answering core requests.
// BUSREQ_ERR_EN adds rsp_err, sticky q_overflow and an empty-queue wait timeout.
module busreq_responder
  import busreq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 16,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                req,
  input  logic [3:0]                req_addr,
  input  logic [WIDTH-1:0]          req_wdata,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_valid,
  output logic                      busy,
  input  logic                      op_push,
  input  logic [WIDTH-1:0]          op_data,
  output logic                      op_ready,
  output logic [$clog2(QDEPTH):0]   op_count
`ifdef BUSREQ_ERR_EN
  ,
  output logic                      rsp_err,
  output logic                      q_overflow
`endif
);
  localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] NREGS_L = 5'(NREGS);

  state_e           state_q, state_d;
  logic [3:0]       req_q, code_q, code_d, addr_q, addr_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [AW-1:0]    idx;
  logic             in_range, reg_we, q_pop, q_full, q_empty, done, timeout;
  logic [WIDTH-1:0] q_dat;

  operand_queue #(.WIDTH(WIDTH), .DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (op_push),
    .push_dat_i (op_data),
    .pop_i      (q_pop),
    .pop_dat_o  (q_dat),
    .count_o    (op_count),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  assign idx       = addr_q[AW-1:0];
  assign in_range  = ({1'b0, addr_q} < NREGS_L);
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign op_ready  = !q_full;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    addr_d      = addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    q_pop       = 1'b0;
    reg_we      = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_q != REQ_IDLE) begin
          state_d = S_DECODE;
          code_d  = req_q;
          addr_d  = req_addr;
        end
      end
      S_DECODE: begin
        done = 1'b1;
        case (code_q)
          REQ_READ:  rsp_data_d = in_range ? regs_q[idx] : '0;
          REQ_WRITE: begin
            reg_we     = in_range;
            rsp_data_d = req_wdata;
          end
          REQ_NEXT_OP: begin
            if (!q_empty) begin
              q_pop      = 1'b1;
              rsp_data_d = q_dat;
            end else begin
              // Empty queue: hold in DECODE until a push lands (or the timeout fires).
              done = timeout;
              if (timeout) rsp_data_d = '0;
            end
          end
          default:   rsp_data_d = '0;
        endcase
        if (done) begin
          state_d     = S_RESPOND;
          rsp_valid_d = 1'b1;
        end
      end
      S_RESPOND: state_d = S_HOLD;
      S_HOLD:    if (req_q == REQ_IDLE) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      code_q      <= '0;
      addr_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req;
      code_q      <= code_d;
      addr_q      <= addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      if (reg_we) regs_q[idx] <= req_wdata;
    end
  end

`ifdef BUSREQ_ERR_EN
  localparam int WW = $clog2(ERR_TIMEOUT);

  logic [WW-1:0] wait_q;
  logic          is_rw, is_legal, rsp_err_q, overflow_q;

  assign timeout  = (wait_q == WW'(ERR_TIMEOUT - 1));
  assign is_rw    = (code_q == REQ_READ) || (code_q == REQ_WRITE);
  assign is_legal = is_rw || (code_q == REQ_NEXT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      rsp_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wait_q     <= (state_q == S_DECODE) ? wait_q + WW'(1) : '0;
      rsp_err_q  <= done && (!is_legal || (is_rw && !in_range) || timeout);
      overflow_q <= overflow_q || (op_push && q_full);
    end
  end

  assign rsp_err    = rsp_err_q;
  assign q_overflow = overflow_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_busreq_responder.sv
// Directed plus randomized bench for busreq_responder against an array/queue reference model.
module tb_busreq_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0, req_addr = '0, req_wdata = '0, op_data = '0;
  logic       op_push = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_valid, busy, op_ready;
  logic [2:0] op_count;
`ifdef BUSREQ_ERR_EN
  logic       rsp_err, q_overflow;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] regs_m [16];
  logic [3:0] q_m [$];

  busreq_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .busy      (busy),
    .op_push   (op_push),
    .op_data   (op_data),
    .op_ready  (op_ready),
    .op_count  (op_count)
`ifdef BUSREQ_ERR_EN
    ,
    .rsp_err    (rsp_err),
    .q_overflow (q_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] v);
    op_push = 1'b1;
    op_data = v;
    tick();
    op_push = 1'b0;
    if (q_m.size() < 4) q_m.push_back(v);
    check("push op_count", op_count, q_m.size());
    check("push op_ready", op_ready, q_m.size() < 4);
  endtask

  // Pulse width, hold stability, release to IDLE and queue occupancy after a response.
  task automatic finish_rsp(input string tag, input logic [3:0] exp_d);
    tick();
    check({tag, " single pulse"}, rsp_valid, 0);
    check({tag, " hold data"}, rsp_data, exp_d);
    check({tag, " busy in hold"}, busy, 1);
    req = 4'b0000;
    tick();
    tick();
    check({tag, " busy released"}, busy, 0);
    check({tag, " op_count"}, op_count, q_m.size());
  endtask

  task automatic xact(input string tag, input logic [3:0] code, input logic [3:0] addr,
                      input logic [3:0] wdata);
    logic [3:0] exp_d;
    int lat;
`ifdef BUSREQ_ERR_EN
    logic exp_e;
    exp_e = !(code inside {4'd1, 4'd2, 4'd3});
`endif
    case (code)
      4'd1:    exp_d = regs_m[addr];
      4'd2:    begin regs_m[addr] = wdata; exp_d = wdata; end
      4'd3:    exp_d = q_m.pop_front();
      default: exp_d = 4'd0;
    endcase
    req = code;
    req_addr = addr;
    req_wdata = wdata;
    lat = 0;
    do begin tick(); lat++; end while (!rsp_valid && lat < 40);
    check({tag, " latency"}, lat, 3);
    check({tag, " data"}, rsp_data, exp_d);
    check({tag, " busy"}, busy, 1);
`ifdef BUSREQ_ERR_EN
    check({tag, " err"}, rsp_err, exp_e);
`endif
    finish_rsp(tag, exp_d);
  endtask

  initial begin
    logic seen;
    int lat;
    for (int i = 0; i < 16; i++) regs_m[i] = '0;

    #1 rst_n = 1'b0;
    #1;
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset busy", busy, 0);
    check("reset op_ready", op_ready, 1);
    check("reset op_count", op_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    push(4'd1);
    push(4'd3);
    xact("nextop first", 4'd3, 4'd0, 4'd0);
    xact("write r5", 4'd2, 4'd5, 4'd4);
    xact("read r5", 4'd1, 4'd5, 4'd0);
    xact("read r6", 4'd1, 4'd6, 4'd0);
    xact("nextop drain", 4'd3, 4'd0, 4'd0);

    for (int v = 1; v <= 5; v++) push(4'(v));
    for (int k = 0; k < 4; k++) xact("nextop wrap", 4'd3, 4'd0, 4'd0);

    // Empty-queue wait state, satisfied by a late push.
    req = 4'b0011;
    seen = 1'b0;
    repeat (8) begin tick(); seen |= rsp_valid; end
    check("wait no rsp_valid", seen, 0);
    check("wait busy", busy, 1);
    push(4'd9);
    lat = 0;
    do begin tick(); lat++; end while (!rsp_valid && lat < 3);
    check("wait rsp within 2", (lat <= 2) && rsp_valid, 1);
    check("wait data", rsp_data, q_m.pop_front());
    finish_rsp("wait", 4'd9);

`ifdef BUSREQ_ERR_EN
    req = 4'b0011;
    lat = 0;
    do begin tick(); lat++; end while (!rsp_valid && lat < 40);
    check("timeout latency", lat, 18);
    check("timeout data", rsp_data, 0);
    check("timeout err", rsp_err, 1);
    finish_rsp("timeout", 4'd0);
`endif

    xact("illegal 0111", 4'd7, 4'd5, 4'd0);
    xact("read r5 after illegal", 4'd1, 4'd5, 4'd0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: push(4'($urandom_range(0, 15)));
        1, 5: xact("rand read", 4'd1, 4'($urandom_range(0, 15)), 4'd0);
        2: xact("rand write", 4'd2, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        3: if (q_m.size() > 0) xact("rand nextop", 4'd3, 4'd0, 4'd0);
           else push(4'($urandom_range(0, 15)));
        default: xact("rand illegal", 4'($urandom_range(4, 15)), 4'($urandom_range(0, 15)), 4'd0);
      endcase
    end

    // Asynchronous reset while holding a response.
    xact("pre-reset write", 4'd2, 4'd5, 4'hA);
    while (q_m.size() < 2) push(4'($urandom_range(1, 15)));
    req = 4'b0001;
    req_addr = 4'd5;
    lat = 0;
    do begin tick(); lat++; end while (!rsp_valid && lat < 40);
    check("pre-reset data", rsp_data, 4'hA);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async rst rsp_data", rsp_data, 0);
    check("async rst rsp_valid", rsp_valid, 0);
    check("async rst busy", busy, 0);
    check("async rst op_ready", op_ready, 1);
    check("async rst op_count", op_count, 0);
    req = 4'b0000;
    for (int i = 0; i < 16; i++) regs_m[i] = '0;
    q_m.delete();
    @(negedge clk);
    rst_n = 1'b1;
    xact("post-reset read r5", 4'd1, 4'd5, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
